// File: rtl/arbitro_somador_sinal.sv
// arbitro_somador_sinal: round-robin arbiter and sequencer for the shared
// mixed-sign 8-bit adder. Two requesters submit (A, B, codigo) over
// valid/ready. One operation is in flight at a time. The result is returned
// with the owner ID, the carry and the signed-overflow flags on a
// back-pressured response port.
//
// Ports:
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   req_valid[1:0]              requester i presents an operation
//   req_ready[1:0]              combinational one-hot grant, idle state only
//   req_a0/1, req_b0/1          8-bit operands per requester
//   req_codigo0/1               2-bit operation code per requester
//   resp_valid/resp_ready       response handshake
//   resp_id                     owner of the result
//   resp_dado                   result mod 256
//   resp_carry                  bit 8 of A + Bext
//   resp_ovf                    signed overflow (code 00 only)
//   contador_ops                completed responses, wraps at 256
module arbitro_somador_sinal (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_b1,
  input  logic [1:0] req_codigo0,
  input  logic [1:0] req_codigo1,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [7:0] resp_dado,
  output logic       resp_carry,
  output logic       resp_ovf,
  output logic [7:0] contador_ops
);

  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    RESP   = 2'd2
  } estado_t;

  estado_t         estado;
  logic            prio;
  logic            op_id;
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic [1:0]      op_codigo;

  logic            ganhador;
  logic [1:0]      concessao;
  logic [DW-1:0]   b_ext;
  logic [DW:0]     soma;
  logic            ovf_calc;

  // Grant selection: prio breaks ties, a lone requester always wins.
  always_comb begin
    ganhador  = 1'b0;
    concessao = 2'b00;
    if (req_valid == 2'b11) begin
      ganhador = prio;
    end else begin
      ganhador = req_valid[1];
    end
    if (!rst && (estado == OCIOSO) && (req_valid != 2'b00)) begin
      concessao[ganhador] = 1'b1;
    end
  end

  assign req_ready = concessao;

  // Operand B extension by code, then the shared 9-bit add.
  always_comb begin
    b_ext = {4'b0000, op_b[3:0]};
    case (op_codigo)
      2'b00:   b_ext = {{4{op_b[3]}}, op_b[3:0]};
      2'b10:   b_ext = op_b;
      default: b_ext = {4'b0000, op_b[3:0]};
    endcase
    soma     = {1'b0, op_a} + {1'b0, b_ext};
    ovf_calc = (op_codigo == 2'b00) && (op_a[DW-1] == b_ext[DW-1])
               && (soma[DW-1] != op_a[DW-1]);
  end

  // Sequencer: accept in OCIOSO, register the sum in CALC, hold in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado       <= OCIOSO;
      prio         <= 1'b0;
      op_id        <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_codigo    <= 2'b00;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_dado    <= '0;
      resp_carry   <= 1'b0;
      resp_ovf     <= 1'b0;
      contador_ops <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (req_valid != 2'b00) begin
            op_id     <= ganhador;
            op_a      <= ganhador ? req_a1 : req_a0;
            op_b      <= ganhador ? req_b1 : req_b0;
            op_codigo <= ganhador ? req_codigo1 : req_codigo0;
            prio      <= ~ganhador;
            estado    <= CALC;
          end
        end
        CALC: begin
          resp_dado  <= soma[DW-1:0];
          resp_carry <= soma[DW];
          resp_ovf   <= ovf_calc;
          resp_id    <= op_id;
          resp_valid <= 1'b1;
          estado     <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid   <= 1'b0;
            contador_ops <= contador_ops + 8'd1;
            estado       <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_somador_sinal.sv
// tb_arbitro_somador_sinal: directed bench for arbitro_somador_sinal with a
// transaction-level reference model checked every cycle, plus literal
// expectations for the listed scenarios.
module tb_arbitro_somador_sinal;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0] req_codigo0, req_codigo1;
  logic       resp_valid, resp_ready, resp_id, resp_carry, resp_ovf;
  logic [7:0] resp_dado, contador_ops;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  arbitro_somador_sinal dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_codigo0(req_codigo0), .req_codigo1(req_codigo1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_dado(resp_dado), .resp_carry(resp_carry), .resp_ovf(resp_ovf),
    .contador_ops(contador_ops)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  function automatic void model_calc(input logic [7:0] a, input logic [7:0] b,
                                     input logic [1:0] c, output logic [7:0] d,
                                     output logic cy, output logic ov);
    int bv, u, sa, s;
    if (c == 2'b00)      bv = b[3] ? int'(b[3:0]) - 16 : int'(b[3:0]);
    else if (c == 2'b10) bv = int'(b);
    else                 bv = int'(b[3:0]);
    u  = int'(a) + (bv & 255);
    d  = u[7:0];
    cy = u[8];
    sa = a[7] ? int'(a) - 256 : int'(a);
    s  = sa + bv;
    ov = (c == 2'b00) && ((s > 127) || (s < -128));
  endfunction

  logic       m_busy = 0, m_pend = 0, m_rv = 0, m_prio = 0, m_id = 0;
  logic [7:0] m_a = 0, m_b = 0;
  logic [1:0] m_c = 0;
  logic [7:0] m_dado = 0;
  logic       m_cy = 0, m_ov = 0, m_rid = 0;
  int         m_cnt = 0;

  // Model: an accepted op yields its result one cycle later, held until taken.
  always @(posedge clk) begin
    logic [1:0] g;
    if (rst) begin
      m_busy = 0; m_pend = 0; m_rv = 0; m_prio = 0; m_cnt = 0;
      m_dado = 0; m_cy = 0; m_ov = 0; m_rid = 0;
    end else if (!m_busy) begin
      g = exp_grant(req_valid, m_prio);
      if (g != 2'b00) begin
        m_id   = g[1];
        m_a    = m_id ? req_a1 : req_a0;
        m_b    = m_id ? req_b1 : req_b0;
        m_c    = m_id ? req_codigo1 : req_codigo0;
        m_prio = ~m_id;
        m_busy = 1;
        m_pend = 1;
      end
    end else if (m_pend) begin
      model_calc(m_a, m_b, m_c, m_dado, m_cy, m_ov);
      m_rid  = m_id;
      m_rv   = 1;
      m_pend = 0;
    end else if (resp_ready) begin
      m_rv   = 0;
      m_busy = 0;
      m_cnt  = (m_cnt + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready),
          32'((rst || m_busy) ? 2'b00 : exp_grant(req_valid, m_prio)));
      chk("resp_valid", 32'(resp_valid), 32'(m_rv));
      chk("resp_id", 32'(resp_id), 32'(m_rid));
      chk("resp_dado", 32'(resp_dado), 32'(m_dado));
      chk("resp_carry", 32'(resp_carry), 32'(m_cy));
      chk("resp_ovf", 32'(resp_ovf), 32'(m_ov));
      chk("contador_ops", 32'(contador_ops), 32'(m_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] c);
    if (id == 0) begin req_a0 = a; req_b0 = b; req_codigo0 = c; end
    else         begin req_a1 = a; req_b1 = b; req_codigo1 = c; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] c, input logic [7:0] ed,
                        input logic ec, input logic eo, input string nm);
    bit got;
    int lat;
    set_req(id, a, b, c);
    req_valid     = 2'b00;
    req_valid[id] = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1; break; end
    end
    chk({nm, "_accept"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    got = 0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin got = 1; break; end
    end
    chk({nm, "_resp_seen"}, 32'(got), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    chk({nm, "_dado"}, 32'(resp_dado), 32'(ed));
    chk({nm, "_carry"}, 32'(resp_carry), 32'(ec));
    chk({nm, "_ovf"}, 32'(resp_ovf), 32'(eo));
    chk({nm, "_id"}, 32'(resp_id), 32'(id));
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   ng, nr;
    bit   g_order [4];
    bit   r_order [4];
    bit   got;

    rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b1;
    req_a0 = 0; req_a1 = 0; req_b0 = 0; req_b1 = 0;
    req_codigo0 = 0; req_codigo1 = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_contador", 32'(contador_ops), 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst = 1'b0;

    // Sign/width rules and overflow cases
    run_op(0, 8'hF0, 8'h08, 2'b00, 8'hE8, 1'b1, 1'b0, "neg_add");
    run_op(1, 8'h10, 8'h0F, 2'b00, 8'h0F, 1'b1, 1'b0, "w_code00");
    run_op(0, 8'h10, 8'h0F, 2'b01, 8'h1F, 1'b0, 1'b0, "w_code01");
    run_op(1, 8'h10, 8'h0F, 2'b11, 8'h1F, 1'b0, 1'b0, "w_code11");
    run_op(0, 8'h10, 8'hFF, 2'b01, 8'h1F, 1'b0, 1'b0, "w_code01_hi");
    run_op(0, 8'h80, 8'h80, 2'b10, 8'h00, 1'b1, 1'b0, "w_code10");
    run_op(0, 8'h7F, 8'h01, 2'b00, 8'h80, 1'b0, 1'b1, "ovf_pos");
    run_op(1, 8'h80, 8'h0F, 2'b00, 8'h7F, 1'b1, 1'b1, "ovf_neg");
    chk("contador_after_8", 32'(contador_ops), 32'd8);

    // Round robin with both requesters valid from reset
    do_reset();
    set_req(0, 8'h01, 8'h01, 2'b01);
    set_req(1, 8'h10, 8'h20, 2'b10);
    req_valid = 2'b11;
    ng = 0; nr = 0;
    for (int i = 0; i < 60 && nr < 4; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00 && ng < 4) begin g_order[ng] = req_ready[1]; ng++; end
      if (resp_valid) begin r_order[nr] = resp_id; nr++; end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("rr_grants", 32'(ng), 32'd4);
    chk("rr_resps", 32'(nr), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant_order", 32'(g_order[k]), 32'(k % 2));
      chk("rr_resp_id", 32'(r_order[k]), 32'(k % 2));
    end
    chk("rr_contador", 32'(contador_ops), 32'd4);

    // Back-pressure: consumer stalls five cycles with another request waiting
    @(posedge clk); #1;
    resp_ready = 1'b0;
    set_req(0, 8'h33, 8'h05, 2'b01);
    set_req(1, 8'h01, 8'h02, 2'b01);
    req_valid = 2'b01;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[0]) begin got = 1; break; end
    end
    chk("bp_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b10;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1; break; end
    end
    chk("bp_resp_seen", 32'(got), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_dado", 32'(resp_dado), 32'h38);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_cycle6_valid", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;

    // Reset while in CALC discards the op and restores priority to requester 0
    set_req(0, 8'h05, 8'h05, 2'b01);
    req_valid = 2'b01;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[0]) begin got = 1; break; end
    end
    chk("rc_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rc_ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rc_resp_valid", 32'(resp_valid), 32'd0);
    chk("rc_contador", 32'(contador_ops), 32'd0);
    chk("rc_prio_reset", 32'(req_ready), 32'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    chk("rc_contador_final", 32'(contador_ops), 32'd1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
